// File: rtl/nco_core.sv
// nco_core: numerically controlled oscillator datapath.
// A 64-bit phase accumulator advances by the active tuning word every clock
// while running. Registered shaping logic turns the phase into square/PWM,
// sawtooth, triangle or inverted-sawtooth samples one cycle later.
//
// Configuration macro: NCO_SYNC_UPDATE_EN
//   defined   - while running, active config loads only on accumulator carry
//               (or every cycle while the active tuning word is zero)
//   undefined - active config loads from the inputs every cycle
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   enable       run (1) / idle (0), level-sensitive
//   wave         0 square/PWM, 1 sawtooth, 2 triangle, 3 inverted sawtooth
//   frequency    64-bit tuning word
//   duty_cycle   square high threshold against phase[63:48]
//   sample       unsigned waveform sample (OUT_W bits)
//   sample_valid sample holds a running value
//   square_out   PWM bit, independent of wave
//   phase_wrap   one-cycle pulse with the first post-wrap sample
module nco_core #(
   parameter int unsigned OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       wave,
   input  logic [63:0]      frequency,
   input  logic [15:0]      duty_cycle,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid,
   output logic             square_out,
   output logic             phase_wrap
);

   localparam int unsigned PH_W   = 64;
   localparam int unsigned DUTY_W = 16;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic                wrap_q, wrap_d;
   logic [PH_W-1:0]     act_freq_q;
   logic [DUTY_W-1:0]   act_duty_q;
   logic [1:0]          act_wave_q;
   logic                cfg_load;
   logic [PH_W:0]       sum_c;

   logic [OUT_W-1:0]    sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                square_q, square_d;
   logic                pwrap_q, pwrap_d;

   logic [OUT_W-1:0]    top_c;
   logic [OUT_W-1:0]    tri_c;
   logic                sq_c;
   logic [OUT_W-1:0]    shape_c;

   // Full 65-bit accumulation; bit 64 is the wrap carry.
   assign sum_c = {1'b0, phase_q} + {1'b0, act_freq_q};

   // State register and phase accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state and accumulator update; a falling enable overrides a carry.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (enable) begin
               phase_d = sum_c[PH_W-1:0];
               wrap_d  = sum_c[PH_W];
            end else begin
               phase_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            phase_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Active config load strobe.
`ifdef NCO_SYNC_UPDATE_EN
   // A zero tuning word never carries, so keep loading until it is non-zero.
   assign cfg_load = (state_q == IDLE) || sum_c[PH_W] || (act_freq_q == '0);
`else
   assign cfg_load = 1'b1;
`endif

   // Active configuration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_freq_q <= '0;
         act_duty_q <= '0;
         act_wave_q <= '0;
      end else if (cfg_load) begin
         act_freq_q <= frequency;
         act_duty_q <= duty_cycle;
         act_wave_q <= wave;
      end
   end

   // Waveform shaping from the registered phase.
   always_comb begin
      top_c   = phase_q[PH_W-1 -: OUT_W];
      tri_c   = phase_q[PH_W-2 -: OUT_W];
      sq_c    = (phase_q[PH_W-1 -: DUTY_W] < act_duty_q);
      shape_c = '0;
      case (act_wave_q)
         2'd0:    shape_c = sq_c ? '1 : '0;
         2'd1:    shape_c = top_c;
         2'd2:    shape_c = phase_q[PH_W-1] ? ~tri_c : tri_c;
         default: shape_c = ~top_c;
      endcase
   end

   // Output stage: follows the FSM by one cycle, zero while idle.
   always_comb begin
      sample_d = '0;
      valid_d  = 1'b0;
      square_d = 1'b0;
      pwrap_d  = 1'b0;
      if (state_q == RUN) begin
         sample_d = shape_c;
         valid_d  = 1'b1;
         square_d = sq_c;
         pwrap_d  = wrap_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q <= '0;
         valid_q  <= 1'b0;
         square_q <= 1'b0;
         pwrap_q  <= 1'b0;
      end else begin
         sample_q <= sample_d;
         valid_q  <= valid_d;
         square_q <= square_d;
         pwrap_q  <= pwrap_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign square_out   = square_q;
   assign phase_wrap   = pwrap_q;

endmodule

// File: tb/tb_nco_core.sv
// Self-checking bench for nco_core (OUT_W = 16).
module tb_nco_core;

   localparam int unsigned OUT_W = 16;
   localparam logic [63:0] F60 = 64'h1000_0000_0000_0000;
   localparam logic [63:0] F61 = 64'h2000_0000_0000_0000;
   localparam logic [63:0] F62 = 64'h4000_0000_0000_0000;
   localparam logic [63:0] F63 = 64'h8000_0000_0000_0000;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [1:0]       wave;
   logic [63:0]      frequency;
   logic [15:0]      duty_cycle;
   logic [OUT_W-1:0] sample;
   logic             sample_valid;
   logic             square_out;
   logic             phase_wrap;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        en;
      logic [1:0]  wv;
      logic [63:0] freq;
      logic [15:0] duty;
      logic [15:0] s;
      logic        v;
      logic        sq;
      logic        wr;
   } vec_t;

   vec_t vt [13];

   nco_core #(.OUT_W(OUT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .wave         (wave),
      .frequency    (frequency),
      .duty_cycle   (duty_cycle),
      .sample       (sample),
      .sample_valid (sample_valid),
      .square_out   (square_out),
      .phase_wrap   (phase_wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] s, input logic v,
                          input logic sq, input logic wr);
      chk({tag, ".sample"},       32'(sample),       32'(s));
      chk({tag, ".sample_valid"}, 32'(sample_valid), 32'(v));
      chk({tag, ".square_out"},   32'(square_out),   32'(sq));
      chk({tag, ".phase_wrap"},   32'(phase_wrap),   32'(wr));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [1:0] w, input logic [63:0] f,
                        input logic [15:0] d);
      enable     = en;
      wave       = w;
      frequency  = f;
      duty_cycle = d;
   endtask

   task automatic go_idle();
      enable = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      logic [15:0] exp_s;
      logic        exp_w;
      logic [15:0] und_s [6];
      logic        und_w [6];
      logic        dff_sq [4];

      // Triangle run with duty 0x8000, then enable fall (outputs after each edge).
      vt[0]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h4000, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 2'd2, F61, 16'h8000, 16'hC000, 1'b1, 1'b1, 1'b0};
      vt[5]  = '{1'b1, 2'd2, F61, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 2'd2, F61, 16'h8000, 16'hBFFF, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h3FFF, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 2'd2, F61, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
      vt[10] = '{1'b1, 2'd2, F61, 16'h8000, 16'h4000, 1'b1, 1'b1, 1'b0};
      vt[11] = '{1'b0, 2'd2, F61, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};
      vt[12] = '{1'b0, 2'd2, F61, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};

      und_s = '{16'h6000, 16'h8FFF, 16'h4FFF, 16'h0FFF, 16'hCFFF, 16'h8FFF};
      und_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      dff_sq = '{1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state.
      rst = 1'b1;
      drive(1'b0, 2'd0, 64'd0, 16'd0);
      #12;
      chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc();
      chk_out("idle", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Table: triangle and enable fall.
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].en, vt[i].wv, vt[i].freq, vt[i].duty);
         cyc();
         chk_out($sformatf("tri[%0d]", i), vt[i].s, vt[i].v, vt[i].sq, vt[i].wr);
      end
      go_idle();

      // Sawtooth through a wrap.
      drive(1'b1, 2'd1, F60, 16'h4000);
      cyc();
      chk("saw.first_edge_valid", 32'(sample_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk_out($sformatf("saw[%0d]", i), 16'((i % 16) << 12), 1'b1,
                 ((i % 16) < 4), (i == 16));
      end
      go_idle();

      // Carry coinciding with enable fall: no wrap pulse.
      drive(1'b1, 2'd1, F60, 16'h0000);
      cyc();
      for (int i = 0; i < 15; i++) cyc();
      chk("cf.pre_sample", 32'(sample), 32'h0000_E000);
      enable = 1'b0;
      cyc();
      chk_out("cf.fall", 16'hF000, 1'b1, 1'b0, 1'b0);
      cyc();
      chk_out("cf.idle", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("cf.idle2_wrap", 32'(phase_wrap), 32'd0);

      // PWM 25% duty.
      drive(1'b1, 2'd0, F60, 16'h4000);
      cyc();
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk_out($sformatf("pwm[%0d]", i), (i < 4) ? 16'hFFFF : 16'h0000, 1'b1,
                 (i < 4), 1'b0);
      end
      go_idle();

      // Duty 0: square never high.
      drive(1'b1, 2'd0, F60, 16'h0000);
      cyc();
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk($sformatf("duty0.square[%0d]", i), 32'(square_out), 32'd0);
         chk($sformatf("duty0.sample[%0d]", i), 32'(sample), 32'd0);
      end
      go_idle();

      // Duty 0xFFFF: low only at phase[63:48] = 0xFFFF.
      drive(1'b1, 2'd0, 64'hFFFF_0000_0000_0000, 16'hFFFF);
      cyc();
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("dutyF.square[%0d]", i), 32'(square_out), 32'(dff_sq[i]));
         chk($sformatf("dutyF.sample[%0d]", i), 32'(sample),
             dff_sq[i] ? 32'h0000_FFFF : 32'h0);
      end
      go_idle();

      // Zero frequency, then pick up 2^63.
      drive(1'b1, 2'd1, 64'd0, 16'h0000);
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_out($sformatf("f0[%0d]", i), 16'h0000, 1'b1, 1'b0, 1'b0);
      end
      frequency = F63;
      cyc();
      chk("f63.load_edge", 32'(sample), 32'h0);
      cyc();
      chk("f63.phase0", 32'(sample), 32'h0);
      cyc();
      chk_out("f63.a", 16'h8000, 1'b1, 1'b0, 1'b0);
      cyc();
      chk_out("f63.b", 16'h0000, 1'b1, 1'b0, 1'b1);
      cyc();
      chk_out("f63.c", 16'h8000, 1'b1, 1'b0, 1'b0);
      go_idle();

      // Mid-period change from sawtooth/2^60 to inverted sawtooth/2^62.
      drive(1'b1, 2'd1, F60, 16'h0000);
      cyc();
      for (int i = 0; i < 6; i++) cyc();
      chk("upd.pre_sample", 32'(sample), 32'h0000_5000);
      wave      = 2'd3;
      frequency = F62;
`ifdef NCO_SYNC_UPDATE_EN
      for (int j = 1; j <= 15; j++) begin
         cyc();
         if (j <= 10) begin
            exp_s = 16'((j + 5) << 12);
            exp_w = 1'b0;
         end else begin
            exp_s = 16'hFFFF - 16'(((j - 11) % 4) << 14);
            exp_w = (((j - 11) % 4) == 0);
         end
         chk($sformatf("upd.sample[%0d]", j), 32'(sample), 32'(exp_s));
         chk($sformatf("upd.wrap[%0d]", j), 32'(phase_wrap), 32'(exp_w));
      end
`else
      for (int j = 0; j < 6; j++) begin
         cyc();
         chk($sformatf("upd.sample[%0d]", j), 32'(sample), 32'(und_s[j]));
         chk($sformatf("upd.wrap[%0d]", j), 32'(phase_wrap), 32'(und_w[j]));
      end
`endif
      go_idle();

      // Asynchronous reset mid-run.
      drive(1'b1, 2'd1, F60, 16'hFFFF);
      cyc();
      cyc();
      cyc();
      chk("rst.pre_square", 32'(square_out), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst.async", 16'h0000, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_out($sformatf("rst.after[%0d]", i), 16'h0000, 1'b0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
